// File: rtl/hood_mode_controller.sv
// Cooktop hood mode controller: power/menu/level/clean buttons drive a mode FSM
// with per-second countdowns for timed modes and an idle auto-off in standby.
module hood_mode_controller #(
   parameter int unsigned T3_SEC    = 60,
   parameter int unsigned WAIT_SEC  = 60,
   parameter int unsigned CLEAN_SEC = 180,
   parameter int unsigned IDLE_SEC  = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1s,
   input  logic       btn_power,
   input  logic       btn_menu,
   input  logic       btn_l1,
   input  logic       btn_l2,
   input  logic       btn_l3,
   input  logic       btn_clean,
   output logic [2:0] state,
   output logic [7:0] countdown,
   output logic       third_used
);

   typedef enum logic [2:0] {
      S_OFF          = 3'b000,
      S_STANDBY      = 3'b001,
      S_MODE_SELECT  = 3'b010,
      S_FIRST_LEVEL  = 3'b011,
      S_SECOND_LEVEL = 3'b100,
      S_THIRD_LEVEL  = 3'b101,
      S_SELF_CLEAN   = 3'b110,
      S_WAIT_STANDBY = 3'b111
   } state_t;

   // Zero load values become 1 so a timed state always lasts at least one tick.
   localparam logic [7:0] T3_LD    = (T3_SEC == 0)    ? 8'd1 : (T3_SEC > 255)    ? 8'd255 : 8'(T3_SEC);
   localparam logic [7:0] WAIT_LD  = (WAIT_SEC == 0)  ? 8'd1 : (WAIT_SEC > 255)  ? 8'd255 : 8'(WAIT_SEC);
   localparam logic [7:0] CLEAN_LD = (CLEAN_SEC == 0) ? 8'd1 : (CLEAN_SEC > 255) ? 8'd255 : 8'(CLEAN_SEC);

   state_t     state_q;
   logic [7:0] idle_cnt;
   logic       any_btn;

   assign any_btn = btn_power | btn_menu | btn_l1 | btn_l2 | btn_l3 | btn_clean;
   assign state   = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_OFF;
         countdown  <= '0;
         third_used <= 1'b0;
         idle_cnt   <= '0;
      end else if (btn_power && state_q != S_OFF) begin
         state_q    <= S_OFF;
         countdown  <= '0;
         third_used <= 1'b0;
         idle_cnt   <= '0;
      end else begin
         idle_cnt <= '0;
         case (state_q)
            S_OFF: begin
               if (btn_power) state_q <= S_STANDBY;
            end
            S_STANDBY: begin
               // Any button counts as activity; a tick only counts when no button acts.
               if (btn_menu) begin
                  state_q <= S_MODE_SELECT;
               end else if (!any_btn && tick_1s) begin
                  if (32'(idle_cnt) + 32'd1 >= IDLE_SEC) begin
                     state_q    <= S_OFF;
                     third_used <= 1'b0;
                  end else begin
                     idle_cnt <= (idle_cnt == '1) ? idle_cnt : idle_cnt + 8'd1;
                  end
               end else if (!any_btn) begin
                  idle_cnt <= idle_cnt;
               end
            end
            S_MODE_SELECT: begin
               if (btn_clean) begin
                  state_q   <= S_SELF_CLEAN;
                  countdown <= CLEAN_LD;
               end else if (btn_menu) begin
                  state_q <= S_STANDBY;
               end else if (btn_l3 && !third_used) begin
                  state_q    <= S_THIRD_LEVEL;
                  countdown  <= T3_LD;
                  third_used <= 1'b1;
               end else if (btn_l2) begin
                  state_q <= S_SECOND_LEVEL;
               end else if (btn_l1) begin
                  state_q <= S_FIRST_LEVEL;
               end
            end
            S_FIRST_LEVEL, S_SECOND_LEVEL: begin
               if (btn_menu) begin
                  state_q   <= S_WAIT_STANDBY;
                  countdown <= WAIT_LD;
               end else if (btn_l2 && state_q == S_FIRST_LEVEL) begin
                  state_q <= S_SECOND_LEVEL;
               end else if (btn_l1 && state_q == S_SECOND_LEVEL) begin
                  state_q <= S_FIRST_LEVEL;
               end
            end
            S_THIRD_LEVEL: begin
               if (btn_menu) begin
                  state_q   <= S_WAIT_STANDBY;
                  countdown <= WAIT_LD;
               end else if (tick_1s) begin
                  if (countdown <= 8'd1) begin
                     state_q   <= S_SECOND_LEVEL;
                     countdown <= '0;
                  end else begin
                     countdown <= countdown - 8'd1;
                  end
               end
            end
            S_SELF_CLEAN, S_WAIT_STANDBY: begin
               if (tick_1s) begin
                  if (countdown <= 8'd1) begin
                     state_q   <= S_STANDBY;
                     countdown <= '0;
                  end else begin
                     countdown <= countdown - 8'd1;
                  end
               end
            end
            default: begin
               state_q   <= S_OFF;
               countdown <= '0;
            end
         endcase
      end
   end

endmodule
